// File: rtl/bin_to_bcd_serial.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Results are held on bcd/overflow and qualified by a one-cycle done pulse.
module bin_to_bcd_serial #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  overflow
);

    localparam int AW = DIGITS * 4;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    logic [BIN_W-1:0]    sreg;
    logic [AW-1:0]       acc;
    logic [CW-1:0]       cnt;
    logic                ovf_int;

    logic [AW-1:0]       adj_acc;
    logic [AW+BIN_W-1:0] shifted;
    logic [AW-1:0]       acc_nxt;
    logic [BIN_W-1:0]    sreg_nxt;
    logic                ovf_nxt;

    // Per-digit +3 on values >= 5; no carry crosses a digit boundary.
    always_comb begin
        adj_acc = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj_acc[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted  = {adj_acc, sreg} << 1;
    assign acc_nxt  = shifted[AW+BIN_W-1 -: AW];
    assign sreg_nxt = shifted[BIN_W-1:0];
    assign ovf_nxt  = ovf_int | adj_acc[AW-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_int  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg    <= bin;
                        acc     <= '0;
                        cnt     <= CW'(BIN_W);
                        ovf_int <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc     <= acc_nxt;
                    sreg    <= sreg_nxt;
                    ovf_int <= ovf_nxt;
                    cnt     <= cnt - CW'(1);
                    // Final shift: publish the post-shift value directly.
                    if (cnt == CW'(1)) begin
                        bcd      <= acc_nxt;
                        overflow <= ovf_nxt;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed-vector bench for bin_to_bcd_serial: default 32b/10-digit
// instance plus an 8b/2-digit instance for overflow truncation.
module tb_bin_to_bcd_serial;

    logic        clk;
    logic        reset;

    logic        start_a;
    logic [31:0] bin_a;
    logic        busy_a;
    logic        done_a;
    logic [39:0] bcd_a;
    logic        overflow_a;

    logic        start_b;
    logic [7:0]  bin_b;
    logic        busy_b;
    logic        done_b;
    logic [7:0]  bcd_b;
    logic        overflow_b;

    int vectors;
    int errors;

    bin_to_bcd_serial u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start_a),
        .bin      (bin_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd      (bcd_a),
        .overflow (overflow_a)
    );

    bin_to_bcd_serial #(
        .BIN_W  (8),
        .DIGITS (2)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start_b),
        .bin      (bin_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd      (bcd_b),
        .overflow (overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bad_nibbles(input logic [39:0] v);
        int n = 0;
        for (int i = 0; i < 10; i++) begin
            if (v[4*i +: 4] > 4'd9) n++;
        end
        return n;
    endfunction

    // Called at posedge+1 with the selected DUT idle.
    task automatic convert(input bit inst, input logic [31:0] v,
                           input logic [39:0] exp_bcd, input logic exp_ovf,
                           input string tag);
        int lat;
        int nbusy;
        int both;
        int w;
        logic [39:0] got;
        logic        ovf;
        w = inst ? 8 : 32;
        lat = 0;
        nbusy = 0;
        both = 0;
        if (inst) begin
            bin_b = v[7:0];
            start_b = 1'b1;
        end else begin
            bin_a = v;
            start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (inst ? (busy_b && done_b) : (busy_a && done_a)) both++;
            if (inst ? done_b : done_a) begin
                lat = c;
                break;
            end
            if (inst ? busy_b : busy_a) nbusy++;
            @(posedge clk);
            #1;
        end
        got = inst ? {32'd0, bcd_b} : bcd_a;
        ovf = inst ? overflow_b : overflow_a;
        check({tag, " latency"}, 64'(lat), 64'(w + 1));
        check({tag, " busy_cycles"}, 64'(nbusy), 64'(w));
        check({tag, " busy_and_done"}, 64'(both), 64'd0);
        check({tag, " bcd"}, 64'(got), 64'(exp_bcd));
        check({tag, " overflow"}, 64'(ovf), 64'(exp_ovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ndone;
        int unstable;
        int spurious;
        logic [39:0] prev;

        vectors = 0;
        errors = 0;
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a = '0;
        bin_b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst bcd", 64'(bcd_a), 64'd0);
        check("rst busy", 64'(busy_a), 64'd0);
        check("rst done", 64'(done_a), 64'd0);
        check("rst ovf", 64'(overflow_a), 64'd0);
        check("rst bcd_b", 64'(bcd_b), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        convert(1'b0, 32'd0, 40'h0, 1'b0, "zero");
        convert(1'b0, 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0, "max");
        check("max nibbles", 64'(bad_nibbles(bcd_a)), 64'd0);
        convert(1'b0, 32'd12345, 40'h00_0001_2345, 1'b0, "12345");
        check("12345 nibbles", 64'(bad_nibbles(bcd_a)), 64'd0);
        convert(1'b0, 32'd9, 40'h9, 1'b0, "nine");
        convert(1'b0, 32'd1234567890, 40'h12_3456_7890, 1'b0, "digits");
        convert(1'b0, 32'd4000000000, 40'h40_0000_0000, 1'b0, "4e9");
        convert(1'b0, 32'd10, 40'h10, 1'b0, "ten");

        convert(1'b1, 32'd255, 40'h55, 1'b1, "b255");
        convert(1'b1, 32'd99, 40'h99, 1'b0, "b99");
        convert(1'b1, 32'd100, 40'h00, 1'b1, "b100");
        convert(1'b1, 32'd0, 40'h00, 1'b0, "b0");

        // Start during SHIFT must be ignored and bin not re-sampled.
        prev = bcd_a;
        ndone = 0;
        unstable = 0;
        bin_a = 32'd7;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done_a) ndone++;
            else if (ndone == 0 && bcd_a !== prev) unstable++;
            @(posedge clk);
            #1;
            if (c == 4) begin
                bin_a = 32'd3;
                start_a = 1'b1;
            end
            if (c == 5) start_a = 1'b0;
        end
        check("ignore done_count", 64'(ndone), 64'd1);
        check("ignore bcd", 64'(bcd_a), 64'h7);
        check("ignore hold", 64'(unstable), 64'd0);

        // Reset mid-conversion clears outputs and suppresses done.
        bin_a = 32'd1000;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst busy", 64'(busy_a), 64'd1);
        reset = 1'b1;
        #1;
        check("async bcd", 64'(bcd_a), 64'd0);
        check("async busy", 64'(busy_a), 64'd0);
        check("async done", 64'(done_a), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_a || busy_a) spurious++;
        end
        check("post_rst idle", 64'(spurious), 64'd0);
        @(posedge clk);
        #1;
        convert(1'b0, 32'd1000, 40'h1000, 1'b0, "1000");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
